// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core types and defaults.
// Holds the widths used across the core and the memory-arbiter state and requester encodings.
package pdp8_pkg;

  localparam int PDP8_ADDR_WIDTH  = 12;
  localparam int PDP8_DATA_WIDTH  = 12;

  // Default memory read latency (legal 1..7) and the IFD starvation threshold.
  localparam int ARB_MEM_LATENCY  = 2;
  localparam int ARB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } mem_arb_state_e;

  typedef enum logic {
    REQ_IFD,
    REQ_EXEC
  } mem_requester_e;

  // Starvation count after a grant: IFD grants and unopposed EXEC grants clear it.
  function automatic logic [7:0] starve_next(input logic [7:0] cnt,
                                             input logic       ifd_granted,
                                             input logic       ifd_waiting,
                                             input int         limit);
    logic [7:0] nxt;
    nxt = '0;
    if (!ifd_granted && ifd_waiting) begin
      nxt = (cnt >= 8'(limit)) ? 8'(limit) : cnt + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single PDP-8 main-memory port between instruction fetch and EXEC.
// EXEC has fixed priority; IFD is forced through after STARVE_LIMIT opposed EXEC grants.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no access in flight; arbitrate requests sampled this cycle
// ARB_ISSUE | mem_en and winner's gnt asserted for exactly one cycle
// ARB_WAIT  | read in flight; counting cycles until mem_rdata is valid
// ARB_RESP  | winner's rd_valid asserted for one cycle; back to IDLE next
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH   = PDP8_ADDR_WIDTH,
  parameter int DATA_WIDTH   = PDP8_DATA_WIDTH,
  parameter int MEM_LATENCY  = ARB_MEM_LATENCY,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  ifd_req,
  input  logic [ADDR_WIDTH-1:0] ifd_addr,
  output logic                  ifd_gnt,
  output logic                  ifd_rd_valid,
  output logic [DATA_WIDTH-1:0] ifd_rd_data,

  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [DATA_WIDTH-1:0] exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_rd_valid,
  output logic [DATA_WIDTH-1:0] exec_rd_data,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WC_W = 3;
  localparam int SC_W = 8;

  mem_arb_state_e        state_q,       state_d;
  mem_requester_e        sel_q,         sel_d;
  logic [WC_W-1:0]       wait_cnt_q,    wait_cnt_d;
  logic [SC_W-1:0]       starve_cnt_q,  starve_cnt_d;

  logic                  mem_en_q,      mem_en_d;
  logic                  mem_we_q,      mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;

  logic                  ifd_gnt_q,       ifd_gnt_d;
  logic                  exec_gnt_q,      exec_gnt_d;
  logic                  ifd_rd_valid_q,  ifd_rd_valid_d;
  logic                  exec_rd_valid_q, exec_rd_valid_d;
  logic [DATA_WIDTH-1:0] ifd_rd_data_q,   ifd_rd_data_d;
  logic [DATA_WIDTH-1:0] exec_rd_data_q,  exec_rd_data_d;

  logic                  ifd_win;
  logic                  exec_win;

  // Priority pick: EXEC first unless IFD has been starved long enough.
  always_comb begin
    ifd_win  = ifd_req && ((starve_cnt_q == SC_W'(STARVE_LIMIT)) || !exec_req);
    exec_win = exec_req && !ifd_win;
  end

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    wait_cnt_d      = wait_cnt_q;
    starve_cnt_d    = starve_cnt_q;
    mem_en_d        = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    ifd_gnt_d       = 1'b0;
    exec_gnt_d      = 1'b0;
    ifd_rd_valid_d  = 1'b0;
    exec_rd_valid_d = 1'b0;
    ifd_rd_data_d   = ifd_rd_data_q;
    exec_rd_data_d  = exec_rd_data_q;

    case (state_q)
      ARB_IDLE: begin
        if (ifd_win || exec_win) begin
          state_d      = ARB_ISSUE;
          sel_d        = ifd_win ? REQ_IFD : REQ_EXEC;
          mem_en_d     = 1'b1;
          mem_we_d     = exec_win && exec_we;
          mem_addr_d   = ifd_win ? ifd_addr : exec_addr;
          mem_wdata_d  = ifd_win ? '0 : exec_wdata;
          ifd_gnt_d    = ifd_win;
          exec_gnt_d   = exec_win;
          starve_cnt_d = starve_next(starve_cnt_q, ifd_win, ifd_req, STARVE_LIMIT);
        end
      end

      ARB_ISSUE: begin
        // mem_we_q still carries the latched direction during the issue cycle.
        if (mem_we_q) begin
          state_d = ARB_IDLE;
        end else begin
          state_d    = ARB_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end

      ARB_WAIT: begin
        wait_cnt_d = wait_cnt_q + WC_W'(1);
        if (wait_cnt_q == WC_W'(MEM_LATENCY)) begin
          state_d    = ARB_RESP;
          wait_cnt_d = '0;
          if (sel_q == REQ_IFD) begin
            ifd_rd_data_d  = mem_rdata;
            ifd_rd_valid_d = 1'b1;
          end else begin
            exec_rd_data_d  = mem_rdata;
            exec_rd_valid_d = 1'b1;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ARB_IDLE;
      sel_q           <= REQ_IFD;
      wait_cnt_q      <= '0;
      starve_cnt_q    <= '0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      ifd_gnt_q       <= 1'b0;
      exec_gnt_q      <= 1'b0;
      ifd_rd_valid_q  <= 1'b0;
      exec_rd_valid_q <= 1'b0;
      ifd_rd_data_q   <= '0;
      exec_rd_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      wait_cnt_q      <= wait_cnt_d;
      starve_cnt_q    <= starve_cnt_d;
      mem_en_q        <= mem_en_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      ifd_gnt_q       <= ifd_gnt_d;
      exec_gnt_q      <= exec_gnt_d;
      ifd_rd_valid_q  <= ifd_rd_valid_d;
      exec_rd_valid_q <= exec_rd_valid_d;
      ifd_rd_data_q   <= ifd_rd_data_d;
      exec_rd_data_q  <= exec_rd_data_d;
    end
  end

  assign ifd_gnt       = ifd_gnt_q;
  assign ifd_rd_valid  = ifd_rd_valid_q;
  assign ifd_rd_data   = ifd_rd_data_q;
  assign exec_gnt      = exec_gnt_q;
  assign exec_rd_valid = exec_rd_valid_q;
  assign exec_rd_data  = exec_rd_data_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifd_req;
  logic [11:0] ifd_addr;
  logic        ifd_gnt;
  logic        ifd_rd_valid;
  logic [11:0] ifd_rd_data;
  logic        exec_req;
  logic        exec_we;
  logic [11:0] exec_addr;
  logic [11:0] exec_wdata;
  logic        exec_gnt;
  logic        exec_rd_valid;
  logic [11:0] exec_rd_data;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_LATENCY(LAT), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ifd_req(ifd_req), .ifd_addr(ifd_addr), .ifd_gnt(ifd_gnt),
    .ifd_rd_valid(ifd_rd_valid), .ifd_rd_data(ifd_rd_data),
    .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
    .exec_wdata(exec_wdata), .exec_gnt(exec_gnt),
    .exec_rd_valid(exec_rd_valid), .exec_rd_data(exec_rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: preset words until written; read data is driven only in the
  // cycle LAT cycles after the strobe, garbage otherwise.
  logic [11:0] wmem   [4096];
  bit          wvalid [4096];
  bit          rv_pipe [1:LAT];
  logic [11:0] ra_pipe [1:LAT];

  function automatic logic [11:0] init_word(input logic [11:0] a);
    case (a)
      12'o0200: return 12'o7402;
      12'o0300: return 12'o1111;
      default:  return {a[5:0], a[11:6]};
    endcase
  endfunction

  always @(posedge clk) begin
    rv_pipe[1] <= (mem_en === 1'b1) && (mem_we === 1'b0);
    ra_pipe[1] <= mem_addr;
    for (int k = 2; k <= LAT; k++) begin
      rv_pipe[k] <= rv_pipe[k-1];
      ra_pipe[k] <= ra_pipe[k-1];
    end
    if ((mem_en === 1'b1) && (mem_we === 1'b1)) begin
      wmem[mem_addr]   <= mem_wdata;
      wvalid[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = !rv_pipe[LAT] ? 12'o5555 :
                     wvalid[ra_pipe[LAT]] ? wmem[ra_pipe[LAT]] : init_word(ra_pipe[LAT]);

  logic [53:0] all_outs;
  assign all_outs = {ifd_gnt, ifd_rd_valid, ifd_rd_data, exec_gnt, exec_rd_valid,
                     exec_rd_data, mem_en, mem_we, mem_addr, mem_wdata};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [1:0] starve_exp [10];

  initial begin
    int g;
    starve_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                   2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    // Reset held with both requesters asking.
    reset_n = 1'b0; ifd_req = 1'b1; ifd_addr = 12'o0200;
    exec_req = 1'b1; exec_we = 1'b0; exec_addr = 12'o0300; exec_wdata = 12'o0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_outs%0d", i), 64'(all_outs), 64'd0);
    end
    reset_n = 1'b1;

    // Simultaneous requests, starve count 0: EXEC first, IFD after EXEC read completes.
    step();
    chk("sim_exec_gnt", {ifd_gnt, exec_gnt, mem_en, mem_we}, 4'b0110);
    chk("sim_exec_addr", mem_addr, 12'o0300);
    exec_req = 1'b0;
    step();
    chk("sim_exec_rv_t2", exec_rd_valid, 1'b0);
    step();
    chk("sim_exec_rv_t3", exec_rd_valid, 1'b0);
    step();
    chk("sim_exec_rv_t4", {exec_rd_valid, exec_rd_data}, {1'b1, 12'o1111});
    step();
    chk("sim_t5_quiet", {ifd_gnt, exec_rd_valid, mem_en}, 3'b000);
    step();
    chk("ifd_gnt", {ifd_gnt, exec_gnt, mem_en, mem_we}, 4'b1010);
    chk("ifd_addr", mem_addr, 12'o0200);
    ifd_req = 1'b0;
    step();
    step();
    chk("ifd_rv_early", ifd_rd_valid, 1'b0);
    step();
    chk("ifd_rd", {ifd_rd_valid, ifd_rd_data}, {1'b1, 12'o7402});
    step();
    chk("ifd_rv_pulse", ifd_rd_valid, 1'b0);
    chk("exec_rd_hold", exec_rd_data, 12'o1111);

    // EXEC write then read back.
    exec_req = 1'b1; exec_we = 1'b1; exec_addr = 12'o0050; exec_wdata = 12'o1234;
    step();
    chk("wr_issue", {exec_gnt, mem_en, mem_we}, 3'b111);
    chk("wr_addr_data", {mem_addr, mem_wdata}, {12'o0050, 12'o1234});
    exec_req = 1'b0;
    step();
    chk("wr_no_rv", {exec_rd_valid, mem_en}, 2'b00);
    exec_req = 1'b1; exec_we = 1'b0;
    step();
    chk("rd_after_wr_gnt", {exec_gnt, mem_en, mem_we, exec_rd_valid}, 4'b1100);
    exec_req = 1'b0;
    step();
    step();
    step();
    chk("rd_after_wr_data", {exec_rd_valid, exec_rd_data}, {1'b1, 12'o1234});
    step();

    // Starvation: both held high; expect E E E E I E E E E I.
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    exec_req = 1'b1; exec_we = 1'b0; exec_addr = 12'o0300;
    g = 0;
    for (int c = 0; c < 200 && g < 10; c++) begin
      step();
      if (ifd_gnt || exec_gnt) begin
        chk($sformatf("starve_grant%0d", g), {ifd_gnt, exec_gnt}, starve_exp[g]);
        if (g == 3) chk("starve_cnt_sat", dut.starve_cnt_q, 4);
        if (g == 4) chk("starve_cnt_clr", dut.starve_cnt_q, 0);
        g++;
      end
    end
    if (g < 10) chk("starve_timeout", g, 10);
    ifd_req = 1'b0; exec_req = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Reset in the middle of an IFD read.
    ifd_req = 1'b1; ifd_addr = 12'o0200;
    step();
    chk("rmid_gnt", {ifd_gnt, mem_en}, 2'b11);
    ifd_req = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("rmid_outs0", 64'(all_outs), 64'd0);
    step();
    chk("rmid_outs1", 64'(all_outs), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rmid_quiet%0d", i), {ifd_rd_valid, ifd_gnt, exec_gnt, mem_en}, 4'b0000);
    end
    ifd_req = 1'b1; ifd_addr = 12'o0300;
    step();
    chk("rmid_new_gnt", {ifd_gnt, mem_en, mem_addr}, {2'b11, 12'o0300});
    ifd_req = 1'b0;
    step();
    step();
    step();
    chk("rmid_new_rd", {ifd_rd_valid, ifd_rd_data}, {1'b1, 12'o1111});
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
